// File: rtl/cvxif_copro_responder.sv
// -----------------------------------------------------------------------------
// cvxif_copro_responder
//
// Coprocessor-side responder for the CV-X-IF offload path. Custom-0
// instructions offered by the issue stage are decoded combinationally. Accepted
// work (everything except CNOP) is queued in a small FIFO. The queued requests
// are executed strictly in order, and each one is returned on the result port
// as a single registered response.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 drop all queued and in-flight work (synchronous)
//   x_issue_valid_i/_ready_o  offload request handshake
//   x_issue_instr_i         offloaded instruction word
//   x_issue_id_i            scoreboard transaction id
//   x_rs1_i, x_rs2_i        source operands
//   x_issue_accept_o        instruction recognised (combinational)
//   x_issue_we_o            accepted instruction writes rd (combinational)
//   x_result_valid_o/_ready_i result handshake
//   x_result_id_o/_data_o/_we_o/_exc_o/_exccode_o  result payload
//
// Operations (opcode 7'b0001011, funct3):
//   000 CADD  rs1 + rs2, one execute cycle
//   001 CNOP  consumed; nothing is queued or returned
//   010 CMUL  low XLEN bits of rs1 * rs2, MUL_LAT execute cycles
//   011 CEXC  exception response, cause 2, no write-back
// -----------------------------------------------------------------------------
module cvxif_copro_responder #(
    parameter int DEPTH         = 4,
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int MUL_LAT       = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     x_issue_valid_i,
    output logic                     x_issue_ready_o,
    input  logic [31:0]              x_issue_instr_i,
    input  logic [TRANS_ID_BITS-1:0] x_issue_id_i,
    input  logic [XLEN-1:0]          x_rs1_i,
    input  logic [XLEN-1:0]          x_rs2_i,
    output logic                     x_issue_accept_o,
    output logic                     x_issue_we_o,
    output logic                     x_result_valid_o,
    input  logic                     x_result_ready_i,
    output logic [TRANS_ID_BITS-1:0] x_result_id_o,
    output logic [XLEN-1:0]          x_result_data_o,
    output logic                     x_result_we_o,
    output logic                     x_result_exc_o,
    output logic [5:0]               x_result_exccode_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [6:0]       OPC_CUSTOM0 = 7'b0001011;
    localparam logic [1:0]       OP_ADD      = 2'b00;
    localparam logic [1:0]       OP_NOP      = 2'b01;
    localparam logic [1:0]       OP_MUL      = 2'b10;
    localparam logic [1:0]       OP_EXC      = 2'b11;
    localparam logic [5:0]       EXC_CODE    = 6'd2;
    localparam logic [PTR_W:0]   PTR_ONE     = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MUL     = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Request FIFO storage and pointers (extra MSB tells full from empty)
    logic [TRANS_ID_BITS-1:0] r_fifo_id  [DEPTH];
    logic [1:0]               r_fifo_op  [DEPTH];
    logic [XLEN-1:0]          r_fifo_rs1 [DEPTH];
    logic [XLEN-1:0]          r_fifo_rs2 [DEPTH];
    logic [PTR_W:0]           r_wr_ptr;
    logic [PTR_W:0]           r_rd_ptr;

    // Execute stage operands
    logic [TRANS_ID_BITS-1:0] r_ex_id;
    logic [1:0]               r_ex_op;
    logic [XLEN-1:0]          r_ex_rs1;
    logic [XLEN-1:0]          r_ex_rs2;
    logic [CNT_W-1:0]         r_cnt;

    // Registered response
    logic [TRANS_ID_BITS-1:0] r_res_id;
    logic [XLEN-1:0]          r_res_data;
    logic                     r_res_we;
    logic                     r_res_exc;
    logic [5:0]               r_res_exccode;

    state_t r_state;
    state_t w_state_nxt;

    logic        w_full;
    logic        w_empty;
    logic        w_ready;
    logic        w_is_custom;
    logic [2:0]  w_funct3;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_exec_done;
    logic [XLEN-1:0] w_mul;
    logic [XLEN-1:0] w_res_data;
    logic        w_res_we;
    logic        w_res_exc;
    logic [5:0]  w_res_exccode;
    logic        w_unused_instr;

    // ---------------------------------------------------------------- decode
    assign w_funct3    = x_issue_instr_i[14:12];
    assign w_is_custom = (x_issue_instr_i[6:0] == OPC_CUSTOM0);
    assign w_accept    = w_is_custom && !w_funct3[2];

    // Only opcode and funct3 participate in decoding.
    assign w_unused_instr = ^{x_issue_instr_i[31:15], x_issue_instr_i[11:7]};

    assign x_issue_accept_o = w_accept;
    assign x_issue_we_o     = w_accept && !w_funct3[0];

    // ----------------------------------------------------------------- FIFO
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_ready = !w_full && !flush_i;
    assign x_issue_ready_o = w_ready;

    // CNOP is consumed by the handshake but never queued.
    assign w_push = x_issue_valid_i && w_ready && w_accept &&
                    (w_funct3[1:0] != OP_NOP);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr[PTR_W-1:0]]  <= x_issue_id_i;
            r_fifo_op[r_wr_ptr[PTR_W-1:0]]  <= w_funct3[1:0];
            r_fifo_rs1[r_wr_ptr[PTR_W-1:0]] <= x_rs1_i;
            r_fifo_rs2[r_wr_ptr[PTR_W-1:0]] <= x_rs2_i;
        end
    end

    // --------------------------------------------------------- execute load
    always_ff @(posedge clk_i) begin
        if (w_pop) begin
            r_ex_id  <= r_fifo_id[r_rd_ptr[PTR_W-1:0]];
            r_ex_op  <= r_fifo_op[r_rd_ptr[PTR_W-1:0]];
            r_ex_rs1 <= r_fifo_rs1[r_rd_ptr[PTR_W-1:0]];
            r_ex_rs2 <= r_fifo_rs2[r_rd_ptr[PTR_W-1:0]];
        end
    end

    // ------------------------------------------------------- result compute
    assign w_mul = r_ex_rs1 * r_ex_rs2;

    always_comb begin
        w_res_data    = '0;
        w_res_we      = 1'b0;
        w_res_exc     = 1'b0;
        w_res_exccode = '0;
        case (r_ex_op)
            OP_ADD: begin
                w_res_data = r_ex_rs1 + r_ex_rs2;
                w_res_we   = 1'b1;
            end
            OP_MUL: begin
                w_res_data = w_mul;
                w_res_we   = 1'b1;
            end
            OP_EXC: begin
                w_res_exc     = 1'b1;
                w_res_exccode = EXC_CODE;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_exec_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_exec_done = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (x_result_ready_i) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush overrides retirement, pops and completion alike.
        if (flush_i) begin
            w_state_nxt = S_IDLE;
            w_pop       = 1'b0;
            w_exec_done = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cnt         <= '0;
            r_res_id      <= '0;
            r_res_data    <= '0;
            r_res_we      <= 1'b0;
            r_res_exc     <= 1'b0;
            r_res_exccode <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            // Counter holds the remaining execute cycles after the first.
            if (w_pop) begin
                r_cnt <= (r_fifo_op[r_rd_ptr[PTR_W-1:0]] == OP_MUL) ? CNT_MUL : '0;
            end else if (r_state == S_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (w_exec_done) begin
                r_res_id      <= r_ex_id;
                r_res_data    <= w_res_data;
                r_res_we      <= w_res_we;
                r_res_exc     <= w_res_exc;
                r_res_exccode <= w_res_exccode;
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign x_result_valid_o   = (r_state == S_RESP);
    assign x_result_id_o      = r_res_id;
    assign x_result_data_o    = r_res_data;
    assign x_result_we_o      = r_res_we;
    assign x_result_exc_o     = r_res_exc;
    assign x_result_exccode_o = r_res_exccode;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Bench for cvxif_copro_responder: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_cvxif_copro_responder;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int IDW   = 3;
    localparam int MLAT  = 3;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] data;
        logic            we;
        logic            exc;
        logic [5:0]      exccode;
    } res_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            iv = 1'b0;
    logic            irdy;
    logic [31:0]     instr = '0;
    logic [IDW-1:0]  iid = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            acc_o;
    logic            iwe_o;
    logic            rv;
    logic            rrdy = 1'b1;
    logic [IDW-1:0]  rid;
    logic [XLEN-1:0] rdata;
    logic            rwe;
    logic            rexc;
    logic [5:0]      rcode;

    int checks   = 0;
    int failures = 0;
    int retired  = 0;
    res_t q[$];

    always #5 clk = ~clk;

    cvxif_copro_responder #(.DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(IDW), .MUL_LAT(MLAT)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .x_issue_valid_i(iv), .x_issue_ready_o(irdy), .x_issue_instr_i(instr),
        .x_issue_id_i(iid), .x_rs1_i(rs1), .x_rs2_i(rs2),
        .x_issue_accept_o(acc_o), .x_issue_we_o(iwe_o),
        .x_result_valid_o(rv), .x_result_ready_i(rrdy), .x_result_id_o(rid),
        .x_result_data_o(rdata), .x_result_we_o(rwe), .x_result_exc_o(rexc),
        .x_result_exccode_o(rcode)
    );

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [6:0] opc);
        return {17'd0, f3, 5'd1, opc};
    endfunction

    // Reference decode and result, straight from the operation table.
    function automatic void model(input logic [31:0] ins, input logic [IDW-1:0] id,
                                  input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  output bit acc, output bit we, output bit queued, output res_t r);
        logic [XLEN-1:0] prod;
        acc = (ins[6:0] == 7'b0001011) && (ins[14:12] <= 3'd3);
        we = 1'b0; queued = 1'b0;
        r = '0; r.id = id;
        prod = a * b;
        if (acc) begin
            case (ins[14:12])
                3'd0: begin we = 1; queued = 1; r.data = a + b; r.we = 1; end
                3'd2: begin we = 1; queued = 1; r.data = prod; r.we = 1; end
                3'd3: begin queued = 1; r.exc = 1; r.exccode = 6'd2; end
                default: ;
            endcase
        end
    endfunction

    // Per-cycle compare process.
    always @(negedge clk) begin
        res_t act, e;
        bit macc, mwe, mq;
        act = {rid, rdata, rwe, rexc, rcode};
        if (rst) begin
            q.delete();
            chk({rv, rwe, rexc} == 3'b000 && rid == '0 && rdata == '0 && rcode == '0,
                "reset_outputs", {rv, act}, '0);
        end else begin
            chk(!rv || q.size() > 0, "no_spurious_result", {rv, act}, '0);
            if (rv && q.size() > 0) begin
                chk(act == q[0], "result_payload", act, q[0]);
                if (rrdy && !flush) begin
                    void'(q.pop_front());
                    retired++;
                end
            end
            if (iv && !flush) begin
                model(instr, iid, rs1, rs2, macc, mwe, mq, e);
                chk(acc_o == macc && iwe_o == mwe, "issue_decode", {acc_o, iwe_o}, {macc, mwe});
                if (irdy && mq) q.push_back(e);
            end
            if (flush) q.delete();
        end
    end

    // Drive one request at posedge+1 and hold it until the handshake edge.
    task automatic issue(input logic [31:0] ins, input logic [IDW-1:0] id,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         output bit acc, output bit we);
        int n = 0;
        iv = 1'b1; instr = ins; iid = id; rs1 = a; rs2 = b;
        @(negedge clk);
        while (!irdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!irdy) chk(1'b0, "issue_timeout", 0, 1);
        acc = acc_o; we = iwe_o;
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(q.size() == 0, "drain_timeout", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bit a, w;
        int r0;
        localparam logic [2:0] F_ADD = 3'd0, F_NOP = 3'd1, F_MUL = 3'd2, F_EXC = 3'd3;
        localparam logic [6:0] C0 = 7'b0001011;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(irdy == 1'b1 && rv == 1'b0, "post_reset_ready", {irdy, rv}, 2'b10);
        @(posedge clk); #1;

        // CADD id=3 5+7 with two-cycle latency
        issue(enc(F_ADD, C0), 3'd3, 64'd5, 64'd7, a, w);
        chk(a && w, "cadd_accept_we", {a, w}, 2'b11);
        @(negedge clk);
        chk(rv == 1'b0, "cadd_not_early0", rv, 0);
        @(posedge clk); @(negedge clk);
        chk(rv == 1'b0, "cadd_not_early1", rv, 0);
        @(posedge clk); @(negedge clk);
        chk(rv && rid == 3'd3 && rdata == 64'd12 && rwe && !rexc, "cadd_literal",
            {rv, rid, rdata, rwe, rexc}, {1'b1, 3'd3, 64'd12, 1'b1, 1'b0});
        @(posedge clk); #1;
        drain();

        // Non-custom opcode: rejected, never answered
        issue(enc(F_ADD, 7'b0110011), 3'd4, 64'd1, 64'd1, a, w);
        chk(a == 1'b0, "reject_accept", a, 0);
        issue(enc(F_NOP, C0), 3'd5, 64'd1, 64'd1, a, w);
        chk(a && !w, "cnop_accept_we", {a, w}, 2'b10);
        repeat (8) @(posedge clk);
        #1;

        // CMUL all-ones * 2 after MUL_LAT+1 cycles
        issue(enc(F_MUL, C0), 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, a, w);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(rv == 1'b0, "cmul_not_early", rv, 0);
        @(posedge clk); @(negedge clk);
        chk(rv && rid == 3'd1 && rdata == 64'hFFFF_FFFF_FFFF_FFFE, "cmul_literal",
            {rv, rid, rdata}, {1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFE});
        @(posedge clk); #1;

        // CEXC id=2
        issue(enc(F_EXC, C0), 3'd2, 64'd9, 64'd9, a, w);
        chk(a && !w, "cexc_accept_we", {a, w}, 2'b10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(rv && rexc && rcode == 6'd2 && !rwe && rdata == '0, "cexc_literal",
            {rv, rexc, rcode, rwe, rdata}, {1'b1, 1'b1, 6'd2, 1'b0, 64'd0});
        @(posedge clk); #1;
        drain();

        // Mixed back-to-back stream with concurrent retirement
        issue(enc(F_MUL, C0), 3'd0, 64'd3, 64'd4, a, w);
        issue(enc(F_ADD, C0), 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, a, w);
        issue(enc(F_NOP, C0), 3'd2, 64'd0, 64'd0, a, w);
        issue(enc(F_EXC, C0), 3'd3, 64'd0, 64'd0, a, w);
        issue(enc(3'd4, C0), 3'd4, 64'd0, 64'd0, a, w);
        issue(enc(F_ADD, C0), 3'd5, 64'd100, 64'd23, a, w);
        issue(enc(F_MUL, C0), 3'd6, 64'h1_0000_0000, 64'h1_0000_0001, a, w);
        drain();

        // Back-pressure: five CADDs fill FIFO plus response register
        rrdy = 1'b0;
        r0 = retired;
        for (int i = 0; i < 5; i++) begin
            issue(enc(F_ADD, C0), 3'(i), 64'(i * 10), 64'd1, a, w);
        end
        @(negedge clk);
        chk(irdy == 1'b0, "full_ready_low", irdy, 0);
        repeat (4) @(posedge clk);
        #1 rrdy = 1'b1;
        drain();
        chk(retired - r0 == 5, "backpressure_count", retired - r0, 5);

        // Flush with three queued and one held in the response register
        rrdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(enc(F_ADD, C0), 3'(i), 64'd2, 64'(i), a, w);
        end
        @(negedge clk);
        chk(rv && rid == 3'd0, "pre_flush_resp", {rv, rid}, {1'b1, 3'd0});
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk(irdy == 1'b0, "flush_ready_low", irdy, 0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk(rv == 1'b0, "flush_valid_low", rv, 0);
        @(posedge clk); #1 rrdy = 1'b1;
        r0 = retired;
        repeat (10) @(posedge clk);
        #1;
        issue(enc(F_ADD, C0), 3'd6, 64'd40, 64'd2, a, w);
        drain();
        chk(retired - r0 == 1, "post_flush_count", retired - r0, 1);

        // Reset in the middle of a CMUL
        issue(enc(F_MUL, C0), 3'd7, 64'd6, 64'd7, a, w);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk(rv == 1'b0 && rdata == '0 && rid == '0, "midreset_outputs", {rv, rid, rdata}, '0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk(irdy == 1'b1, "midreset_ready", irdy, 1);
        r0 = retired;
        repeat (10) @(posedge clk);
        #1;
        chk(retired == r0, "midreset_no_stale", retired - r0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
